digit_osd_overlay: RTL and testbench

DIGIT_OSD_OVERLAY -- requirements
Module: digit_osd_overlay

---
 rtl/digit_osd_overlay.sv | 204 ++++++++++++++++++++
 tb/tb_digit_osd_overlay.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/digit_osd_overlay.sv
// digit_osd_overlay: draws a fixed-position string of 8x16 decimal glyphs,
// magnified by 2^SCALE_LSB, over a video stream. Digits are double-buffered
// and commit on the next frame edge. An optional blink toggles the string
// every BLINK_FRAMES frames. The pixel path has a fixed two-cycle latency.
module digit_osd_overlay #(
    parameter int          NUM_CHARS    = 5,
    parameter int          SCALE_LSB    = 2,
    parameter logic [11:0] X0           = 12'd0,
    parameter logic [11:0] Y0           = 12'd0,
    parameter logic [23:0] FG_COLOR     = 24'hFFFFFF,
    parameter logic [23:0] BG_COLOR     = 24'h000000,
    parameter bit          BG_OPAQUE    = 1'b1,
    parameter int          BLINK_FRAMES = 30
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [11:0]            x,
    input  logic [11:0]            y,
    input  logic                   i_hs,
    input  logic                   i_vs,
    input  logic                   i_de,
    input  logic [23:0]            i_data,
    input  logic [4*NUM_CHARS-1:0] digits,
    input  logic                   digits_load,
    input  logic                   osd_en,
    input  logic                   blink_en,
    output logic                   o_hs,
    output logic                   o_vs,
    output logic                   o_de,
    output logic [23:0]            o_data,
    output logic                   o_pending
);

    localparam int          DW         = 4 * NUM_CHARS;
    localparam logic [12:0] SPAN_W     = 13'(NUM_CHARS * (8 << SCALE_LSB));
    localparam logic [12:0] SPAN_H     = 13'(16 << SCALE_LSB);
    localparam logic [7:0]  BLINK_LAST = 8'(BLINK_FRAMES - 1);

    // 8x16 font: top row is the most significant byte, leftmost column is the
    // MSB of each byte. Codes 10..15 render blank.
    function automatic logic [127:0] glyph_rom(input logic [3:0] code);
        logic [127:0] g;
        case (code)
            4'd0:    g = 128'h00003C66666E76666666663C00000000;
            4'd1:    g = 128'h00001838781818181818187E00000000;
            4'd2:    g = 128'h00003C6606060C183060667E00000000;
            4'd3:    g = 128'h00003C6606061C060606663C00000000;
            4'd4:    g = 128'h00000C1C3C6CCCFE0C0C0C1E00000000;
            4'd5:    g = 128'h00007E6060607C060606663C00000000;
            4'd6:    g = 128'h00001C3060607C666666663C00000000;
            4'd7:    g = 128'h00007E6606060C183030303000000000;
            4'd8:    g = 128'h00003C6666663C666666663C00000000;
            4'd9:    g = 128'h00003C6666663E0606060C3800000000;
            default: g = 128'h0;
        endcase
        return g;
    endfunction

    logic [DW-1:0] shadow_r;
    logic [DW-1:0] active_r;
    logic          pending_r;
    logic          vs_prev_r;
    logic          blink_flag_r;
    logic [7:0]    frame_cnt_r;
    logic          frame_edge_s;
    logic          vis_s;

    logic [12:0]   dx_s;
    logic [12:0]   dy_s;
    logic          hit_s;
    logic [2:0]    slot_s;
    logic [2:0]    col_s;
    logic [3:0]    row_s;

    logic          hit1_r;
    logic [2:0]    slot1_r;
    logic [2:0]    col1_r;
    logic [3:0]    row1_r;
    logic          vis1_r;
    logic [23:0]   data1_r;
    logic          hs1_r;
    logic          vs1_r;
    logic          de1_r;

    logic [3:0]    code_s;
    logic [127:0]  glyph_s;
    logic          font_bit_s;
    logic [23:0]   pix_s;

    assign frame_edge_s = i_vs & ~vs_prev_r;
    assign vis_s        = osd_en & blink_flag_r;
    assign o_pending    = pending_r;

    // Remember last vsync level so a rising vsync marks the frame edge
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vs_prev_r <= 1'b0;
        end else begin
            vs_prev_r <= i_vs;
        end
    end

    // Double-buffered digit string: load into shadow, commit to active on a frame edge
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            shadow_r  <= {DW{1'b1}};
            active_r  <= {DW{1'b1}};
            pending_r <= 1'b0;
        end else if (digits_load && frame_edge_s) begin
            shadow_r  <= digits;
            active_r  <= digits;
            pending_r <= 1'b0;
        end else if (digits_load) begin
            shadow_r  <= digits;
            pending_r <= 1'b1;
        end else if (frame_edge_s && pending_r) begin
            active_r  <= shadow_r;
            pending_r <= 1'b0;
        end
    end

    // Blink phase: count frames and flip visibility every BLINK_FRAMES frames
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            frame_cnt_r  <= 8'd0;
            blink_flag_r <= 1'b1;
        end else if (!blink_en) begin
            frame_cnt_r  <= 8'd0;
            blink_flag_r <= 1'b1;
        end else if (frame_edge_s) begin
            if (frame_cnt_r == BLINK_LAST) begin
                frame_cnt_r  <= 8'd0;
                blink_flag_r <= ~blink_flag_r;
            end else begin
                frame_cnt_r  <= frame_cnt_r + 8'd1;
            end
        end
    end

    // Region hit and glyph coordinates; the subtraction is only meaningful when x>=X0, y>=Y0
    always_comb begin
        dx_s   = {1'b0, x} - {1'b0, X0};
        dy_s   = {1'b0, y} - {1'b0, Y0};
        hit_s  = (x >= X0) && (y >= Y0) && (dx_s < SPAN_W) && (dy_s < SPAN_H);
        col_s  = dx_s[SCALE_LSB +: 3];
        slot_s = dx_s[SCALE_LSB + 3 +: 3];
        row_s  = dy_s[SCALE_LSB +: 4];
    end

    // Stage 1: register geometry, visibility, pixel data and syncs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hit1_r  <= 1'b0;
            slot1_r <= 3'd0;
            col1_r  <= 3'd0;
            row1_r  <= 4'd0;
            vis1_r  <= 1'b0;
            data1_r <= 24'd0;
            hs1_r   <= 1'b0;
            vs1_r   <= 1'b0;
            de1_r   <= 1'b0;
        end else begin
            hit1_r  <= hit_s;
            slot1_r <= slot_s;
            col1_r  <= col_s;
            row1_r  <= row_s;
            vis1_r  <= vis_s;
            data1_r <= i_data;
            hs1_r   <= i_hs;
            vs1_r   <= i_vs;
            de1_r   <= i_de;
        end
    end

    // Font lookup and pixel selection; bit index 127-(8*row+col) equals ~{row,col}
    always_comb begin
        code_s     = active_r[{slot1_r, 2'b00} +: 4];
        glyph_s    = glyph_rom(code_s);
        font_bit_s = glyph_s[~{row1_r, col1_r}];
        if (hit1_r && vis1_r && font_bit_s) begin
            pix_s = FG_COLOR;
        end else if (hit1_r && vis1_r && BG_OPAQUE) begin
            pix_s = BG_COLOR;
        end else begin
            pix_s = data1_r;
        end
    end

    // Stage 2: register the output pixel and the aligned syncs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            o_data <= 24'd0;
            o_hs   <= 1'b0;
            o_vs   <= 1'b0;
            o_de   <= 1'b0;
        end else begin
            o_data <= pix_s;
            o_hs   <= hs1_r;
            o_vs   <= vs1_r;
            o_de   <= de1_r;
        end
    end

endmodule

// File: tb/tb_digit_osd_overlay.sv
// Bench for digit_osd_overlay: two instances share stimulus, one with default
// parameters, one with transparent background and a 2-frame blink period.
// The driver pushes expected {vs,hs,data} per pixel; a monitor pops on o_de.
module tb_digit_osd_overlay;

    logic        clk;
    logic        rst_n;
    logic [11:0] x;
    logic [11:0] y;
    logic        i_hs;
    logic        i_vs;
    logic        i_de;
    logic [23:0] i_data;
    logic [19:0] digits;
    logic        digits_load;
    logic        osd_en;
    logic        blink_en;

    logic        o_hs1, o_vs1, o_de1, o_pending1;
    logic [23:0] o_data1;
    logic        o_hs2, o_vs2, o_de2, o_pending2;
    logic [23:0] o_data2;

    int          n_checks;
    int          n_fail;
    logic [25:0] q1[$];
    logic [25:0] q2[$];
    logic [25:0] exp1_v;
    logic [25:0] exp2_v;

    digit_osd_overlay dut1 (
        .clk(clk), .rst_n(rst_n), .x(x), .y(y),
        .i_hs(i_hs), .i_vs(i_vs), .i_de(i_de), .i_data(i_data),
        .digits(digits), .digits_load(digits_load), .osd_en(osd_en), .blink_en(blink_en),
        .o_hs(o_hs1), .o_vs(o_vs1), .o_de(o_de1), .o_data(o_data1), .o_pending(o_pending1)
    );

    digit_osd_overlay #(.BG_OPAQUE(1'b0), .BLINK_FRAMES(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .x(x), .y(y),
        .i_hs(i_hs), .i_vs(i_vs), .i_de(i_de), .i_data(i_data),
        .digits(digits), .digits_load(digits_load), .osd_en(osd_en), .blink_en(blink_en),
        .o_hs(o_hs2), .o_vs(o_vs2), .o_de(o_de2), .o_data(o_data2), .o_pending(o_pending2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // one active pixel; e1/e2 are the hand-computed outputs of dut1/dut2
    task automatic pix(input logic [11:0] px, input logic [11:0] py, input logic [23:0] d,
                       input logic [23:0] e1, input logic [23:0] e2);
        x      = px;
        y      = py;
        i_data = d;
        i_de   = 1'b1;
        i_hs   = 1'b1;
        q1.push_back({1'b0, 1'b1, e1});
        q2.push_back({1'b0, 1'b1, e2});
        tick();
        i_de   = 1'b0;
        i_hs   = 1'b0;
    endtask

    task automatic frame_edge();
        i_vs = 1'b1;
        tick();
        i_vs = 1'b0;
        tick();
    endtask

    task automatic load(input logic [19:0] d);
        digits      = d;
        digits_load = 1'b1;
        tick();
        digits_load = 1'b0;
    endtask

    task automatic check_pending(input string name, input logic exp);
        check({name, "_p1"}, {31'd0, o_pending1}, {31'd0, exp});
        check({name, "_p2"}, {31'd0, o_pending2}, {31'd0, exp});
    endtask

    // Monitor: every presented pixel must match the oldest outstanding expectation
    always @(negedge clk) begin
        if (o_de1 === 1'b1) begin
            if (q1.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL mon1_unexpected: got %0h expected no pixel", o_data1);
            end else begin
                exp1_v = q1.pop_front();
                check("mon1_pixel", {6'd0, o_vs1, o_hs1, o_data1}, {6'd0, exp1_v});
            end
        end
        if (o_de2 === 1'b1) begin
            if (q2.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL mon2_unexpected: got %0h expected no pixel", o_data2);
            end else begin
                exp2_v = q2.pop_front();
                check("mon2_pixel", {6'd0, o_vs2, o_hs2, o_data2}, {6'd0, exp2_v});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    bit vis_tab [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst_n = 1'b0; x = 12'd0; y = 12'd0; i_hs = 1'b1; i_vs = 1'b1; i_de = 1'b1;
        i_data = 24'h777777; digits = 20'd0; digits_load = 1'b0;
        osd_en = 1'b1; blink_en = 1'b0;
        tick();
        tick();
        check("rst_data1", {8'd0, o_data1}, 32'd0);
        check("rst_data2", {8'd0, o_data2}, 32'd0);
        check("rst_sync1", {29'd0, o_hs1, o_vs1, o_de1}, 32'd0);
        check("rst_sync2", {29'd0, o_hs2, o_vs2, o_de2}, 32'd0);
        check_pending("rst", 1'b0);
        rst_n = 1'b1; i_hs = 1'b0; i_vs = 1'b0; i_de = 1'b0;
        tick();

        // digits 00345 committed on a frame edge; slot0='5', slot1='4', slot2='3'
        load(20'h00345);
        check_pending("load1", 1'b1);
        frame_edge();
        check_pending("commit1", 1'b0);
        pix(12'd0,   12'd8,  24'hA5A5A5, 24'h000000, 24'hA5A5A5);
        pix(12'd4,   12'd8,  24'hA5A5A5, 24'hFFFFFF, 24'hFFFFFF);
        pix(12'd20,  12'd24, 24'hA5A5A5, 24'hFFFFFF, 24'hFFFFFF);
        pix(12'd27,  12'd24, 24'hA5A5A5, 24'h000000, 24'hA5A5A5);
        pix(12'd32,  12'd28, 24'hA5A5A5, 24'hFFFFFF, 24'hFFFFFF);
        pix(12'd60,  12'd28, 24'hA5A5A5, 24'h000000, 24'hA5A5A5);
        pix(12'd72,  12'd8,  24'hA5A5A5, 24'hFFFFFF, 24'hFFFFFF);
        // just outside the string / last pixel inside
        pix(12'd160, 12'd8,  24'h123456, 24'h123456, 24'h123456);
        pix(12'd4,   12'd64, 24'h123456, 24'h123456, 24'h123456);
        pix(12'd159, 12'd63, 24'h123456, 24'h000000, 24'h123456);

        // two loads within one frame: display unchanged until edge, last one wins
        load(20'h11111);
        check_pending("load2", 1'b1);
        pix(12'd4, 12'd8, 24'hA5A5A5, 24'hFFFFFF, 24'hFFFFFF);
        load(20'h22222);
        check_pending("load3", 1'b1);
        pix(12'd4, 12'd8, 24'hA5A5A5, 24'hFFFFFF, 24'hFFFFFF);
        frame_edge();
        check_pending("commit2", 1'b0);
        pix(12'd4,  12'd8,  24'hA5A5A5, 24'h000000, 24'hA5A5A5);
        pix(12'd12, 12'd8,  24'hA5A5A5, 24'hFFFFFF, 24'hFFFFFF);
        pix(12'd12, 12'd12, 24'hA5A5A5, 24'h000000, 24'hA5A5A5);

        // load coincident with frame edge goes straight to active
        digits = 20'h99999; digits_load = 1'b1; i_vs = 1'b1;
        tick();
        digits_load = 1'b0; i_vs = 1'b0;
        check_pending("coincident", 1'b0);
        tick();
        pix(12'd4, 12'd24, 24'hA5A5A5, 24'h000000, 24'hA5A5A5);
        pix(12'd8, 12'd24, 24'hA5A5A5, 24'hFFFFFF, 24'hFFFFFF);

        // blink: dut2 visible 2 frames, hidden 2; dut1 (30 frames) stays visible
        blink_en = 1'b1;
        tick();
        for (int i = 0; i < 6; i++) begin
            frame_edge();
            pix(12'd8, 12'd24, 24'h0F0F0F, 24'hFFFFFF,
                vis_tab[i] ? 24'hFFFFFF : 24'h0F0F0F);
        end
        blink_en = 1'b0;
        tick();
        pix(12'd8, 12'd24, 24'h0F0F0F, 24'hFFFFFF, 24'hFFFFFF);

        // reset mid-line with a string pending
        load(20'h88888);
        check_pending("load4", 1'b1);
        tick();
        tick();
        rst_n = 1'b0; x = 12'd8; y = 12'd24; i_data = 24'h777777;
        i_de = 1'b1; i_hs = 1'b1; i_vs = 1'b1;
        tick();
        check("midrst_data1", {8'd0, o_data1}, 32'd0);
        check("midrst_data2", {8'd0, o_data2}, 32'd0);
        check("midrst_sync1", {29'd0, o_hs1, o_vs1, o_de1}, 32'd0);
        check("midrst_sync2", {29'd0, o_hs2, o_vs2, o_de2}, 32'd0);
        check_pending("midrst", 1'b0);
        rst_n = 1'b1; i_vs = 1'b0;
        pix(12'd200, 12'd200, 24'h777777, 24'h777777, 24'h777777);
        pix(12'd8,   12'd24,  24'h777777, 24'h000000, 24'h777777);
        frame_edge();
        check_pending("post_rst_edge", 1'b0);
        pix(12'd8,   12'd24,  24'h777777, 24'h000000, 24'h777777);

        repeat (4) tick();
        check("drain_q1", q1.size(), 32'd0);
        check("drain_q2", q2.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
